// File: rtl/ni_irq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ni_irq_ctrl_if
// Purpose  : CPU configuration port of the NI interrupt controller.
//            The CPU side uses the master modport and the controller uses the
//            slave modport.
// Signals  : cfg_en_i    access strobe
//            cfg_we_i    byte write enables; all zero means a read
//            cfg_addr_i  byte address, word aligned
//            cfg_data_i  write data
//            cfg_data_o  registered read data
// Revision : 1.0 - initial release
// ============================================================================
interface ni_irq_ctrl_if #(
  parameter int ADDR_W = 8
) ();
  logic              cfg_en_i;
  logic [3:0]        cfg_we_i;
  logic [ADDR_W-1:0] cfg_addr_i;
  logic [31:0]       cfg_data_i;
  logic [31:0]       cfg_data_o;

  modport master (
    output cfg_en_i, cfg_we_i, cfg_addr_i, cfg_data_i,
    input  cfg_data_o
  );

  modport slave (
    input  cfg_en_i, cfg_we_i, cfg_addr_i, cfg_data_i,
    output cfg_data_o
  );
endinterface
`default_nettype wire

// File: rtl/ni_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ni_irq_ctrl
// Purpose  : Parametrised interrupt controller for the DMNI network interface.
//            Each source has an enable and a level/edge mode. Pending state
//            is held in a latch that software can set or clear with W1C
//            writes. A claim register returns the lowest active source. The
//            block drives the single CPU irq line.
// Ports    : clk_i   clock
//            rst_i   synchronous active-high reset
//            src_i   raw source levels (N_SRC)
//            gate_i  per-source suppression of irq_o (N_SRC)
//            irq_o   registered interrupt request
//            cfg     configuration port (ni_irq_ctrl_if.slave)
// Map      : 0x00 IE, 0x04 MODE, 0x08 IP (W1C), 0x0C SET, 0x10 CLAIM, 0x14 RAW
// Revision : 1.0 - initial release
// ============================================================================
module ni_irq_ctrl #(
  parameter int               N_SRC  = 8,
  parameter int               ADDR_W = 8,
  parameter logic [N_SRC-1:0] RST_IE = '0
) (
  input  wire logic             clk_i,
  input  wire logic             rst_i,
  input  wire logic [N_SRC-1:0] src_i,
  input  wire logic [N_SRC-1:0] gate_i,
  output logic                  irq_o,
  ni_irq_ctrl_if.slave          cfg
);

  localparam logic [ADDR_W-1:0] c_A_IE    = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] c_A_MODE  = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] c_A_IP    = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] c_A_SET   = ADDR_W'(8'h0C);
  localparam logic [ADDR_W-1:0] c_A_CLAIM = ADDR_W'(8'h10);
  localparam logic [ADDR_W-1:0] c_A_RAW   = ADDR_W'(8'h14);

  logic [N_SRC-1:0] r_ie;
  logic [N_SRC-1:0] r_mode;
  logic [N_SRC-1:0] r_latch;
  logic [N_SRC-1:0] r_src_q;
  logic [31:0]      r_rdata;

  logic             w_wr;
  logic             w_rd;
  logic [31:0]      w_bmask;
  logic [N_SRC-1:0] w_wmask;
  logic [N_SRC-1:0] w_wd;
  logic [N_SRC-1:0] w_ip;
  logic [N_SRC-1:0] w_act;
  logic             w_claim_vld;
  logic [7:0]       w_claim_id;
  logic [N_SRC-1:0] w_claim_oh;
  logic [N_SRC-1:0] w_set;
  logic [N_SRC-1:0] w_clr;
  logic [31:0]      w_rmux;

  assign w_wr = cfg.cfg_en_i && (cfg.cfg_we_i != 4'b0000);
  assign w_rd = cfg.cfg_en_i && (cfg.cfg_we_i == 4'b0000);

  // Byte-lane mask truncated to the implemented sources, so that bits at or
  // above N_SRC are never written.
  assign w_bmask = {{8{cfg.cfg_we_i[3]}}, {8{cfg.cfg_we_i[2]}},
                    {8{cfg.cfg_we_i[1]}}, {8{cfg.cfg_we_i[0]}}};
  assign w_wmask = N_SRC'(w_bmask);
  assign w_wd    = N_SRC'(cfg.cfg_data_i & w_bmask);

  // Level sources are pending directly from the pin. Edge sources are
  // pending only through the latch.
  assign w_ip  = r_latch | (~r_mode & src_i);
  assign w_act = w_ip & r_ie & ~gate_i;

  // Scan from the top so that the lowest active index is the last one written.
  always_comb begin
    w_claim_vld = 1'b0;
    w_claim_id  = 8'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_act[i]) begin
        w_claim_vld = 1'b1;
        w_claim_id  = 8'(i);
      end
    end
  end

  assign w_claim_oh = w_claim_vld ? (N_SRC'(1) << w_claim_id) : '0;

  // The set term is ORed in after the clear term, so an edge or a SET write
  // wins over a W1C or claim clear on the same bit in the same cycle.
  assign w_set = (r_mode & src_i & ~r_src_q)
               | ((w_wr && cfg.cfg_addr_i == c_A_SET) ? w_wd : '0);
  assign w_clr = ((w_wr && cfg.cfg_addr_i == c_A_IP) ? w_wd : '0)
               | ((w_rd && cfg.cfg_addr_i == c_A_CLAIM) ? w_claim_oh : '0);

  always_comb begin
    w_rmux = 32'd0;
    case (cfg.cfg_addr_i)
      c_A_IE:    w_rmux = 32'(r_ie);
      c_A_MODE:  w_rmux = 32'(r_mode);
      c_A_IP:    w_rmux = 32'(w_ip);
      c_A_CLAIM: w_rmux = {w_claim_vld, 23'd0, w_claim_id};
      c_A_RAW:   w_rmux = 32'(src_i);
      default:   w_rmux = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ie    <= RST_IE;
      r_mode  <= '0;
      r_latch <= '0;
      r_src_q <= '0;
      r_rdata <= 32'd0;
      irq_o   <= 1'b0;
    end else begin
      r_src_q <= src_i;
      r_latch <= (r_latch & ~w_clr) | w_set;
      irq_o   <= |w_act;
      if (w_wr && cfg.cfg_addr_i == c_A_IE) begin
        r_ie <= (r_ie & ~w_wmask) | w_wd;
      end
      if (w_wr && cfg.cfg_addr_i == c_A_MODE) begin
        r_mode <= (r_mode & ~w_wmask) | w_wd;
      end
      if (w_rd) begin
        r_rdata <= w_rmux;
      end
    end
  end

  assign cfg.cfg_data_o = r_rdata;

endmodule
`default_nettype wire
